// File: rtl/cmplx_mult_seq.sv
// Sequential complex multiplier: (a_re + j*a_im) x (b_re + j*b_im) using one
// signed shift-add core that retires one multiplier bit per clock.
module cmplx_mult_seq #(
  parameter int W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic                busy,
  output logic                done,
  output logic signed [2*W:0] p_re,
  output logic signed [2*W:0] p_im
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic signed [W-1:0]  a_re_q, a_re_d, a_im_q, a_im_d;
  logic signed [W-1:0]  b_re_q, b_re_d, b_im_q, b_im_d;
  logic signed [2*W-1:0] psum_q, psum_d;
  logic signed [2*W:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [2*W:0]  p_re_q, p_re_d, p_im_q, p_im_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [1:0]           idx_q, idx_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic signed [W-1:0]   mcand, mplier;
  logic signed [2*W-1:0] shifted, addend, psum_nxt;
  logic signed [2*W:0]   prod_ext;

  // Product order: P0=a_re*b_re, P1=a_im*b_im, P2=a_re*b_im, P3=a_im*b_re.
  always_comb begin
    mcand  = a_re_q;
    mplier = b_re_q;
    unique case (idx_q)
      2'd0: begin mcand = a_re_q; mplier = b_re_q; end
      2'd1: begin mcand = a_im_q; mplier = b_im_q; end
      2'd2: begin mcand = a_re_q; mplier = b_im_q; end
      2'd3: begin mcand = a_im_q; mplier = b_re_q; end
    endcase
  end

  // The multiplier MSB carries negative weight, so that partial is subtracted.
  assign shifted  = {{W{mcand[W-1]}}, mcand} <<< bit_q;
  assign addend   = !mplier[bit_q]      ? '0 :
                    (bit_q == LAST_BIT) ? -shifted : shifted;
  assign psum_nxt = psum_q + addend;
  assign prod_ext = {psum_nxt[2*W-1], psum_nxt};

  always_comb begin
    // NOTE: every signal driven here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    state_d  = state_q;
    a_re_d   = a_re_q;
    a_im_d   = a_im_q;
    b_re_d   = b_re_q;
    b_im_d   = b_im_q;
    psum_d   = psum_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    p_re_d   = p_re_q;
    p_im_d   = p_im_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_re_d   = a_re;
          a_im_d   = a_im;
          b_re_d   = b_re;
          b_im_d   = b_im;
          psum_d   = '0;
          acc_re_d = '0;
          acc_im_d = '0;
          bit_d    = '0;
          idx_d    = '0;
          state_d  = MUL;
        end
      end

      MUL: begin
        if (bit_q == LAST_BIT) begin
          unique case (idx_q)
            2'd0: acc_re_d = acc_re_q + prod_ext;
            2'd1: acc_re_d = acc_re_q - prod_ext;
            2'd2: acc_im_d = acc_im_q + prod_ext;
            2'd3: acc_im_d = acc_im_q + prod_ext;
          endcase
          psum_d = '0;
          bit_d  = '0;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            p_re_d  = acc_re_d;
            p_im_d  = acc_im_d;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          psum_d = psum_nxt;
          bit_d  = bit_q + CW'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MUL);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      a_re_q   <= '0;
      a_im_q   <= '0;
      b_re_q   <= '0;
      b_im_q   <= '0;
      psum_q   <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      p_re_q   <= '0;
      p_im_q   <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_re_q   <= a_re_d;
      a_im_q   <= a_im_d;
      b_re_q   <= b_re_d;
      b_im_q   <= b_im_d;
      psum_q   <= psum_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      p_re_q   <= p_re_d;
      p_im_q   <= p_im_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p_re = p_re_q;
  assign p_im = p_im_q;

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// Bench for cmplx_mult_seq: directed corners plus a random regression, with a
// scoreboard queue filled by the driver and drained by a done-triggered monitor.
module tb_cmplx_mult_seq;

  localparam int W   = 5;
  localparam int LAT = 4 * W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic signed [W-1:0] a_re, a_im, b_re, b_im;
  logic                busy, done;
  logic signed [2*W:0] p_re, p_im;

  always #5 clk = ~clk;

  cmplx_mult_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_re  (a_re),
    .a_im  (a_im),
    .b_re  (b_re),
    .b_im  (b_im),
    .busy  (busy),
    .done  (done),
    .p_re  (p_re),
    .p_im  (p_im)
  );

  typedef struct {
    int re;
    int im;
  } res_t;

  res_t exp_q[$];
  int   checks         = 0;
  int   errors         = 0;
  int   dones_seen     = 0;
  int   dones_expected = 0;
  int   last_re        = 0;
  int   last_im        = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: textbook complex product on plain integers.
  function automatic res_t model(input int ar, input int ai, input int br, input int bi);
    res_t r;
    r.re = ar * br - ai * bi;
    r.im = ar * bi + ai * br;
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    res_t e;
    if (done === 1'b1) begin
      dones_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("p_re", int'(p_re), e.re);
        check("p_im", int'(p_im), e.im);
      end
    end
  end

  // Issues one operation from IDLE and follows it to its done pulse. With
  // disturb set, operands are scrambled and stray starts hit edges 3 and 19.
  task automatic run_op(input logic signed [W-1:0] ar, input logic signed [W-1:0] ai,
                        input logic signed [W-1:0] br, input logic signed [W-1:0] bi,
                        input bit disturb);
    int   n;
    int   busy_cnt;
    res_t e;
    a_re  = ar;
    a_im  = ai;
    b_re  = br;
    b_im  = bi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(int'(ar), int'(ai), int'(br), int'(bi));
    exp_q.push_back(e);
    dones_expected++;
    check("p_re_hold", int'(p_re), last_re);
    check("p_im_hold", int'(p_im), last_im);
    n        = 0;
    busy_cnt = 0;
    while (n <= LAT + 4 && done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      if (disturb) begin
        if (n == 1) begin
          a_re = W'($urandom);
          a_im = W'($urandom);
          b_re = W'($urandom);
          b_im = W'($urandom);
        end
        start = (n == 2 || n == 18);
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("done_latency", n, LAT);
    check("busy_cycles", busy_cnt, LAT);
    check("busy_in_done", int'(busy), 0);
    last_re = e.re;
    last_im = e.im;
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
  endtask

  // Starts an operation and resets it mid-flight; no done may follow.
  task automatic abort_op(input logic signed [W-1:0] ar, input logic signed [W-1:0] ai,
                          input logic signed [W-1:0] br, input logic signed [W-1:0] bi,
                          input int at);
    int stray;
    a_re  = ar;
    a_im  = ai;
    b_re  = br;
    b_im  = bi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (at) begin
      @(posedge clk); #1;
    end
    check("busy_before_abort", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_p_re", int'(p_re), 0);
    check("abort_p_im", int'(p_im), 0);
    last_re = 0;
    last_im = 0;
    stray   = 0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (done === 1'b1) stray++;
    end
    check("no_done_after_abort", stray, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_re  = '0;
    a_im  = '0;
    b_re  = '0;
    b_im  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_p_re", int'(p_re), 0);
    check("reset_p_im", int'(p_im), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(5'sd1, 5'sd2, 5'sd3, 5'sd4, 1'b0);
    run_op(-5'sd16, -5'sd16, -5'sd16, -5'sd16, 1'b0);
    run_op(5'sd15, 5'sd15, -5'sd16, 5'sd15, 1'b0);
    run_op(-5'sd16, 5'sd15, -5'sd16, -5'sd16, 1'b0);
    run_op(5'sd3, -5'sd5, -5'sd7, 5'sd2, 1'b1);
    abort_op(-5'sd9, 5'sd11, 5'sd6, -5'sd13, 10);
    run_op(5'sd0, 5'sd0, 5'sd7, -5'sd3, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    check("done_count", dones_seen, dones_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
